// File: rtl/cache_lookup_pipe.sv
// Pipelined L1 tag lookup: per-set valid/dirty/tree-PLRU state, a two-entry response
// buffer with valid/ready handshakes, fill/invalidate forwarding into S1, and a flush walker.
module cache_lookup_pipe #(
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 4,
  parameter int TAG_BITS   = 22,
  parameter int INDEX_BITS = $clog2(NUM_SETS),
  parameter int WAY_BITS   = $clog2(NUM_WAYS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [INDEX_BITS-1:0]        req_index,
  input  logic [TAG_BITS-1:0]          req_tag,
  input  logic                         req_write,
  output logic                         tag_rd_en,
  output logic [INDEX_BITS-1:0]        tag_rd_index,
  input  logic [NUM_WAYS*TAG_BITS-1:0] tag_rd,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_hit,
  output logic                         rsp_multi_hit,
  output logic [WAY_BITS-1:0]          rsp_way,
  output logic [WAY_BITS-1:0]          rsp_victim_way,
  output logic                         rsp_victim_valid,
  output logic                         rsp_victim_dirty,
  input  logic                         fill_valid,
  input  logic [INDEX_BITS-1:0]        fill_index,
  input  logic [WAY_BITS-1:0]          fill_way,
  input  logic                         fill_dirty,
  input  logic                         inv_valid,
  input  logic [INDEX_BITS-1:0]        inv_index,
  input  logic [WAY_BITS-1:0]          inv_way,
  input  logic                         flush_req,
  output logic                         flush_busy,
  output logic                         flush_done
);

  localparam int PLRU_BITS = NUM_WAYS - 1;
  localparam int RSP_BITS  = 4 + 2 * WAY_BITS;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DRAIN = 2'd1, ST_WALK = 2'd2} state_t;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  r_valid;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  r_dirty;
  logic [NUM_SETS-1:0][PLRU_BITS-1:0] r_plru;
  logic                               r_s1_valid;
  logic [INDEX_BITS-1:0]              r_s1_index;
  logic [TAG_BITS-1:0]                r_s1_tag;
  logic                               r_s1_write;
  logic [1:0]                         r_count;
  logic [RSP_BITS-1:0]                r_head;
  logic [RSP_BITS-1:0]                r_tail;
  state_t                             r_state;
  logic [INDEX_BITS-1:0]              r_flush_cnt;
  logic                               r_flush_done;

  logic                               w_accept;
  logic                               w_pop;
  logic                               w_fill_here;
  logic                               w_inv_here;
  logic                               w_flush_here;
  logic [NUM_WAYS-1:0]                w_fill_mask;
  logic [NUM_WAYS-1:0]                w_inv_mask;
  logic [NUM_WAYS-1:0]                w_s1_valid_v;
  logic [NUM_WAYS-1:0]                w_s1_dirty_v;
  logic [PLRU_BITS-1:0]               w_s1_plru_v;
  logic [NUM_WAYS-1:0]                w_match;
  logic                               w_hit;
  logic                               w_multi;
  logic [WAY_BITS-1:0]                w_hit_way;
  logic [WAY_BITS-1:0]                w_victim;
  logic                               w_victim_valid;
  logic                               w_victim_dirty;
  logic [RSP_BITS-1:0]                w_rsp_new;
  logic                               w_hit_upd;
  logic [PLRU_BITS-1:0]               w_fill_base;

  // Heap-ordered tree: node bit 0 points at the lower half, 1 at the upper half.
  function automatic logic [PLRU_BITS-1:0] plru_touch(input logic [PLRU_BITS-1:0] p,
                                                       input logic [WAY_BITS-1:0] way);
    logic [PLRU_BITS-1:0] t;
    t = p;
    for (int l = 0; l < WAY_BITS; l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        if (int'(way >> (WAY_BITS - l)) == k) t[(1 << l) - 1 + k] = ~way[WAY_BITS-1-l];
      end
    end
    return t;
  endfunction

  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [PLRU_BITS-1:0] p);
    logic [WAY_BITS-1:0] v;
    v = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        if (int'(v >> (WAY_BITS - l)) == k) v[WAY_BITS-1-l] = p[(1 << l) - 1 + k];
      end
    end
    return v;
  endfunction

  function automatic logic [WAY_BITS-1:0] lowest_one(input logic [NUM_WAYS-1:0] vec);
    logic [WAY_BITS-1:0] r;
    r = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (vec[w]) r = WAY_BITS'(w);
    end
    return r;
  endfunction

  assign req_ready    = (r_state == ST_IDLE) && ((r_count + {1'b0, r_s1_valid}) < 2'd2);
  assign w_accept     = req_valid && req_ready;
  assign tag_rd_en    = w_accept;
  assign tag_rd_index = req_index;
  assign rsp_valid    = (r_count != 2'd0);
  assign w_pop        = rsp_valid && rsp_ready;

  // S1 sees this cycle's fill/invalidate/flush writes; flush beats inv beats fill.
  assign w_fill_here  = fill_valid && (fill_index == r_s1_index);
  assign w_inv_here   = inv_valid && (inv_index == r_s1_index);
  assign w_flush_here = (r_state == ST_WALK) && (r_flush_cnt == r_s1_index);
  assign w_fill_mask  = w_fill_here ? (NUM_WAYS'(1) << fill_way) : '0;
  assign w_inv_mask   = w_inv_here ? (NUM_WAYS'(1) << inv_way) : '0;
  assign w_s1_valid_v = w_flush_here ? '0 : ((r_valid[r_s1_index] | w_fill_mask) & ~w_inv_mask);
  assign w_s1_dirty_v = w_flush_here ? '0 :
                        (((r_dirty[r_s1_index] & ~w_fill_mask) | (fill_dirty ? w_fill_mask : '0))
                         & ~w_inv_mask);
  assign w_s1_plru_v  = w_flush_here ? '0 :
                        (w_fill_here ? plru_touch(r_plru[r_s1_index], fill_way) : r_plru[r_s1_index]);

  // Tag compare against the SRAM read returned this cycle.
  always_comb begin
    w_match = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_match[w] = w_s1_valid_v[w] && (tag_rd[w*TAG_BITS +: TAG_BITS] == r_s1_tag);
    end
  end

  assign w_hit          = |w_match;
  assign w_multi        = |(w_match & (w_match - NUM_WAYS'(1)));
  assign w_hit_way      = lowest_one(w_match);
  assign w_victim       = (&w_s1_valid_v) ? plru_victim(w_s1_plru_v) : lowest_one(~w_s1_valid_v);
  assign w_victim_valid = w_s1_valid_v[w_victim];
  assign w_victim_dirty = w_victim_valid && w_s1_dirty_v[w_victim];
  assign w_rsp_new      = {w_hit, w_multi, w_hit_way, w_victim, w_victim_valid, w_victim_dirty};
  assign w_hit_upd      = r_s1_valid && w_hit;
  // A fill into the set being hit is applied on top of the hit's own touch.
  assign w_fill_base    = (w_hit_upd && (r_s1_index == fill_index)) ?
                          plru_touch(r_plru[fill_index], w_hit_way) : r_plru[fill_index];

  assign rsp_hit          = r_head[RSP_BITS-1];
  assign rsp_multi_hit    = r_head[RSP_BITS-2];
  assign rsp_way          = r_head[2*WAY_BITS+1 -: WAY_BITS];
  assign rsp_victim_way   = r_head[WAY_BITS+1 -: WAY_BITS];
  assign rsp_victim_valid = r_head[1];
  assign rsp_victim_dirty = r_head[0];
  assign flush_busy       = (r_state != ST_IDLE);
  assign flush_done       = r_flush_done;

  // S1 capture and two-entry response buffer; head drives the response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_index <= '0;
      r_s1_tag   <= '0;
      r_s1_write <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_index <= req_index;
        r_s1_tag   <= req_tag;
        r_s1_write <= req_write;
      end
      case ({r_s1_valid, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= w_rsp_new;
          else                 r_tail <= w_rsp_new;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= w_rsp_new;
          end else begin
            r_head <= r_tail;
            r_tail <= w_rsp_new;
          end
        end
        default: r_count <= r_count;
      endcase
    end
  end

  // Flush sequencer: drain S1, then clear one set per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_flush_cnt  <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        ST_IDLE:  if (flush_req) r_state <= ST_DRAIN;
        ST_DRAIN: if (!r_s1_valid) begin
          r_state     <= ST_WALK;
          r_flush_cnt <= '0;
        end
        ST_WALK: begin
          r_flush_cnt <= r_flush_cnt + INDEX_BITS'(1);
          if (r_flush_cnt == INDEX_BITS'(NUM_SETS - 1)) begin
            r_state      <= ST_IDLE;
            r_flush_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Line state writes; later assignments take priority over earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
      r_plru  <= '0;
    end else begin
      if (w_hit_upd) begin
        r_plru[r_s1_index] <= plru_touch(r_plru[r_s1_index], w_hit_way);
        if (r_s1_write) r_dirty[r_s1_index][w_hit_way] <= 1'b1;
      end
      if (fill_valid) begin
        r_valid[fill_index][fill_way] <= 1'b1;
        r_dirty[fill_index][fill_way] <= fill_dirty;
        r_plru[fill_index]            <= plru_touch(w_fill_base, fill_way);
      end
      if (inv_valid) begin
        r_valid[inv_index][inv_way] <= 1'b0;
        r_dirty[inv_index][inv_way] <= 1'b0;
      end
      if (r_state == ST_WALK) begin
        r_valid[r_flush_cnt] <= '0;
        r_dirty[r_flush_cnt] <= '0;
        r_plru[r_flush_cnt]  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cache_lookup_pipe.sv
// Directed bench for cache_lookup_pipe with a one-cycle-latency tag SRAM model.
module tb_cache_lookup_pipe;

  localparam logic [21:0] TAG_A = 22'h00A01;
  localparam logic [21:0] TAG_B = 22'h00B02;
  localparam logic [21:0] TAG_C = 22'h00C03;
  localparam logic [21:0] TAG_D = 22'h00D04;
  localparam logic [21:0] TAG_X = 22'h003FF;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_index;
  logic [21:0] req_tag;
  logic        req_write;
  logic        tag_rd_en;
  logic [5:0]  tag_rd_index;
  logic [87:0] tag_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_hit;
  logic        rsp_multi_hit;
  logic [1:0]  rsp_way;
  logic [1:0]  rsp_victim_way;
  logic        rsp_victim_valid;
  logic        rsp_victim_dirty;
  logic        fill_valid;
  logic [5:0]  fill_index;
  logic [1:0]  fill_way;
  logic        fill_dirty;
  logic        inv_valid;
  logic [5:0]  inv_index;
  logic [1:0]  inv_way;
  logic        flush_req;
  logic        flush_busy;
  logic        flush_done;

  logic [21:0] tb_tags [0:63][0:3];
  int          n_checks;
  int          n_fail;
  logic [31:0] l_hit, l_multi, l_way, l_vway, l_vvalid, l_vdirty, l_lat;

  cache_lookup_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_tag(req_tag), .req_write(req_write),
    .tag_rd_en(tag_rd_en), .tag_rd_index(tag_rd_index), .tag_rd(tag_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_multi_hit(rsp_multi_hit), .rsp_way(rsp_way), .rsp_victim_way(rsp_victim_way),
    .rsp_victim_valid(rsp_victim_valid), .rsp_victim_dirty(rsp_victim_dirty),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way),
    .fill_dirty(fill_dirty),
    .inv_valid(inv_valid), .inv_index(inv_index), .inv_way(inv_way),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag SRAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (tag_rd_en) begin
      for (int w = 0; w < 4; w++) tag_rd[w*22 +: 22] <= tb_tags[tag_rd_index][w];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_fill(input logic [5:0] idx, input logic [1:0] way,
                         input logic [21:0] tag, input logic dirty);
    @(negedge clk);
    fill_valid = 1'b1; fill_index = idx; fill_way = way; fill_dirty = dirty;
    tb_tags[idx][way] = tag;
    @(negedge clk);
    fill_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [5:0] idx, input logic [21:0] tag, input logic wr);
    int waited;
    @(negedge clk);
    req_valid = 1'b1; req_index = idx; req_tag = tag; req_write = wr;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) check_eq("req_ready_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
    l_lat = 32'd1;
    while (!rsp_valid && l_lat < 32'd20) begin
      @(negedge clk);
      l_lat++;
    end
    if (!rsp_valid) check_eq("rsp_timeout", 32'(rsp_valid), 32'd1);
    l_hit = 32'(rsp_hit); l_multi = 32'(rsp_multi_hit); l_way = 32'(rsp_way);
    l_vway = 32'(rsp_victim_way); l_vvalid = 32'(rsp_victim_valid);
    l_vdirty = 32'(rsp_victim_dirty);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] tq [4];
    int          n_acc;
    int          busy_cycles;
    int          rdy_seen;
    int          done_seen;
    n_checks = 0; n_fail = 0;
    for (int s = 0; s < 64; s++) for (int w = 0; w < 4; w++) tb_tags[s][w] = 22'h0;
    tag_rd = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_index = '0; req_tag = '0; req_write = 1'b0;
    rsp_ready = 1'b1; fill_valid = 1'b0; fill_index = '0; fill_way = '0; fill_dirty = 1'b0;
    inv_valid = 1'b0; inv_index = '0; inv_way = '0; flush_req = 1'b0;
    tq[0] = TAG_A; tq[1] = TAG_B; tq[2] = TAG_C; tq[3] = TAG_D;
    repeat (3) @(negedge clk);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_flush_busy", 32'(flush_busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);

    // Lookup into an empty cache.
    do_lookup(6'd5, 22'h01234, 1'b0);
    check_eq("t1_latency", l_lat, 32'd2);
    check_eq("t1_hit", l_hit, 32'd0);
    check_eq("t1_victim_way", l_vway, 32'd0);
    check_eq("t1_victim_valid", l_vvalid, 32'd0);

    // Fill set 5, hit way 2, then steer PLRU back onto the dirtied way.
    for (int w = 0; w < 4; w++) do_fill(6'd5, 2'(w), tq[w], 1'b0);
    do_lookup(6'd5, TAG_C, 1'b0);
    check_eq("t2_hit", l_hit, 32'd1);
    check_eq("t2_way", l_way, 32'd2);
    check_eq("t2_multi", l_multi, 32'd0);
    check_eq("t2_victim_way", l_vway, 32'd0);
    check_eq("t2_victim_valid", l_vvalid, 32'd1);
    do_lookup(6'd5, TAG_C, 1'b1);
    do_lookup(6'd5, TAG_D, 1'b0);
    do_lookup(6'd5, TAG_A, 1'b0);
    do_lookup(6'd5, TAG_B, 1'b0);
    do_lookup(6'd5, TAG_X, 1'b0);
    check_eq("t2_miss_hit", l_hit, 32'd0);
    check_eq("t2_miss_way", l_way, 32'd0);
    check_eq("t2_victim_way2", l_vway, 32'd2);
    check_eq("t2_victim_dirty", l_vdirty, 32'd1);

    // Touch order 0,1,2,3 then a hit on way 0.
    for (int w = 0; w < 4; w++) begin
      do_lookup(6'd5, tq[w], 1'b0);
      check_eq("t3_hit_way", l_way, 32'(w));
    end
    do_lookup(6'd5, TAG_X, 1'b0);
    check_eq("t3_victim_after_0123", l_vway, 32'd0);
    check_eq("t3_victim_dirty0", l_vdirty, 32'd0);
    do_lookup(6'd5, TAG_A, 1'b0);
    do_lookup(6'd5, TAG_X, 1'b0);
    check_eq("t3_victim_after_hit0", l_vway, 32'd2);
    check_eq("t3_victim_dirty2", l_vdirty, 32'd1);

    // Backpressure: only two requests fit while responses are held.
    @(negedge clk);
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 4; c++) begin
      req_valid = 1'b1; req_index = 6'd5; req_tag = tq[n_acc]; req_write = 1'b0;
      if (req_ready) n_acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check_eq("t4_accepted", 32'(n_acc), 32'd2);
    check_eq("t4_req_ready_low", 32'(req_ready), 32'd0);
    check_eq("t4_head_way", 32'(rsp_way), 32'd0);
    @(negedge clk);
    check_eq("t4_head_stable", 32'(rsp_way), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_second_valid", 32'(rsp_valid), 32'd1);
    check_eq("t4_second_way", 32'(rsp_way), 32'd1);
    @(negedge clk);
    check_eq("t4_drained", 32'(rsp_valid), 32'd0);
    check_eq("t4_req_ready_high", 32'(req_ready), 32'd1);

    // Invalidate forwarded into the compare stage.
    req_valid = 1'b1; req_index = 6'd5; req_tag = TAG_C;
    @(negedge clk);
    req_valid = 1'b0;
    inv_valid = 1'b1; inv_index = 6'd5; inv_way = 2'd2;
    @(negedge clk);
    inv_valid = 1'b0;
    check_eq("t5_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("t5_hit", 32'(rsp_hit), 32'd0);
    check_eq("t5_victim_way", 32'(rsp_victim_way), 32'd2);
    check_eq("t5_victim_valid", 32'(rsp_victim_valid), 32'd0);
    check_eq("t5_victim_dirty", 32'(rsp_victim_dirty), 32'd0);
    do_lookup(6'd5, TAG_C, 1'b0);
    check_eq("t5_after_inv_hit", l_hit, 32'd0);

    // Duplicate tag in two valid ways.
    do_fill(6'd7, 2'd0, 22'h00055, 1'b0);
    do_fill(6'd7, 2'd1, 22'h00055, 1'b0);
    do_lookup(6'd7, 22'h00055, 1'b0);
    check_eq("mh_hit", l_hit, 32'd1);
    check_eq("mh_multi", l_multi, 32'd1);
    check_eq("mh_way", l_way, 32'd0);
    check_eq("mh_victim_way", l_vway, 32'd2);

    // Flush with a dirty line present; a second flush_req mid-walk is ignored.
    do_fill(6'd9, 2'd1, 22'h00099, 1'b1);
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    busy_cycles = 0; rdy_seen = 0;
    while (flush_busy && busy_cycles < 200) begin
      busy_cycles++;
      if (req_ready) rdy_seen++;
      flush_req = (busy_cycles == 10);
      @(negedge clk);
    end
    flush_req = 1'b0;
    check_eq("t6_busy_cycles", 32'(busy_cycles), 32'd65);
    check_eq("t6_req_blocked", 32'(rdy_seen), 32'd0);
    check_eq("t6_done_pulse", 32'(flush_done), 32'd1);
    @(negedge clk);
    check_eq("t6_done_one_cycle", 32'(flush_done), 32'd0);
    do_lookup(6'd9, 22'h00099, 1'b0);
    check_eq("t6_hit_after_flush", l_hit, 32'd0);
    check_eq("t6_vvalid_after_flush", l_vvalid, 32'd0);
    check_eq("t6_vdirty_after_flush", l_vdirty, 32'd0);
    do_lookup(6'd5, TAG_A, 1'b0);
    check_eq("t6_set5_cleared", l_hit, 32'd0);

    // Reset in the middle of a walk.
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t6_mid_walk_busy", 32'(flush_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", 32'(flush_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_req_ready", 32'(req_ready), 32'd1);
    done_seen = 0;
    for (int c = 0; c < 70; c++) begin
      if (flush_done || flush_busy) done_seen++;
      @(negedge clk);
    end
    check_eq("t6_no_stale_flush", 32'(done_seen), 32'd0);
    do_lookup(6'd5, TAG_A, 1'b0);
    check_eq("t6_post_rst_latency", l_lat, 32'd2);
    check_eq("t6_post_rst_hit", l_hit, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
